// File: rtl/multicycle_control.sv
// Control FSM for the multicycle datapath: fetch, decode, execute, memory, write-back.
// All outputs decode from the current state and the opcode/func latched at the end of fetch.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [31:0]      Instr,
    input  logic             Mem_ack,
    input  logic             Zero_in,
    output logic             Mem_req,
    output logic             IR_LdEn,
    output logic             PC_LdEn,
    output logic             PC_sel,
    output logic             RF_B_sel,
    output logic             ALU_Bin_SEL,
    output logic [3:0]       ALU_func,
    output logic             Mem_WrEn,
    output logic             RF_WrEn,
    output logic             RF_WrData_sel,
    output logic             Illegal_op,
    output logic [CNT_W-1:0] Instr_cnt,
    output logic [2:0]       State_dbg
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DEC = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_B     = 6'b111111;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [3:0]       func_q, func_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;
    logic             op_legal, op_branch, op_mem, dec_bin_sel;
    logic [3:0]       dec_alu_func;

    // Only opcode and func reach the control path; the remaining instruction bits feed the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr[25:4];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IF;
            op_q    <= '0;
            func_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        op_legal     = 1'b1;
        op_branch    = 1'b0;
        op_mem       = 1'b0;
        dec_bin_sel  = 1'b0;
        dec_alu_func = 4'b0000;
        case (op_q)
            OP_RTYPE: dec_alu_func = func_q;
            OP_ADDI:  dec_bin_sel  = 1'b1;
            OP_ANDI:  begin dec_bin_sel = 1'b1; dec_alu_func = 4'b0010; end
            OP_ORI:   begin dec_bin_sel = 1'b1; dec_alu_func = 4'b0011; end
            OP_LW, OP_SW: begin dec_bin_sel = 1'b1; op_mem = 1'b1; end
            OP_BEQ, OP_BNE: begin op_branch = 1'b1; dec_alu_func = 4'b0001; end
            OP_B:     op_branch = 1'b1;
            default:  op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        func_d  = func_q;
        cnt_inc = 1'b0;
        case (state_q)
            S_IF: if (Mem_ack) begin
                op_d    = Instr[31:26];
                func_d  = Instr[3:0];
                state_d = S_DEC;
            end
            S_DEC: state_d = op_legal ? S_EXE : S_IF;
            S_EXE: begin
                if (op_mem) begin
                    state_d = S_MEM;
                end else if (op_branch) begin
                    state_d = S_IF;
                    cnt_inc = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: if (Mem_ack) begin
                if (op_q == OP_LW) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                    cnt_inc = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IF;
                cnt_inc = 1'b1;
            end
            default: state_d = S_IF;
        endcase
        cnt_d = cnt_inc ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_comb begin
        Mem_req       = 1'b0;
        IR_LdEn       = 1'b0;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_SEL   = 1'b0;
        ALU_func      = 4'b0000;
        Mem_WrEn      = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        Illegal_op    = 1'b0;
        case (state_q)
            S_IF: begin
                Mem_req = 1'b1;
                IR_LdEn = Mem_ack;
                PC_LdEn = Mem_ack;
            end
            S_DEC: begin
                Illegal_op = !op_legal;
                RF_B_sel   = (op_q == OP_SW) || (op_q == OP_BEQ) || (op_q == OP_BNE);
            end
            S_EXE: begin
                ALU_Bin_SEL = dec_bin_sel;
                ALU_func    = dec_alu_func;
                if (op_q == OP_BEQ) begin
                    PC_LdEn = Zero_in;
                    PC_sel  = Zero_in;
                end else if (op_q == OP_BNE) begin
                    PC_LdEn = !Zero_in;
                    PC_sel  = !Zero_in;
                end else if (op_q == OP_B) begin
                    PC_LdEn = 1'b1;
                    PC_sel  = 1'b1;
                end
            end
            // ALU controls stay put so the address/result is stable through memory and write-back.
            S_MEM: begin
                ALU_Bin_SEL = dec_bin_sel;
                ALU_func    = dec_alu_func;
                Mem_req     = 1'b1;
                Mem_WrEn    = (op_q == OP_SW);
            end
            S_WB: begin
                ALU_Bin_SEL   = dec_bin_sel;
                ALU_func      = dec_alu_func;
                RF_WrEn       = 1'b1;
                RF_WrData_sel = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign Instr_cnt = cnt_q;
    assign State_dbg = state_q;

endmodule
